// File: rtl/digit_entry.sv
// digit_entry
// Converts a stream of decimal key presses into a signed two's-complement
// operand. It keeps a BCD digit stack so that a backspace can rebuild the
// binary magnitude exactly from the remaining digits.
//
// Ports:
//   clk          - system clock, all logic on the rising edge
//   reset        - synchronous, active-high reset
//   key_valid    - one-cycle strobe, key_code is present
//   key_code     - 0-9 digit, 10 negate, 11 backspace, 12 clear, 13-15 ignored
//   key_ready    - high while a key will be accepted (IDLE)
//   value        - signed operand, registered
//   length       - magnitude digit count 0..MAX_DIGITS, registered
//   negative     - sign flag
//   busy         - high while the magnitude is rebuilt after a backspace
//   overflow_err - one-cycle pulse when a digit is rejected
module digit_entry #(
  parameter int WIDTH      = 21,
  parameter int MAX_DIGITS = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] value,
  output logic [3:0]       length,
  output logic             negative,
  output logic             busy,
  output logic             overflow_err
);

  typedef enum logic {IDLE, REBUILD} state_t;

  state_t           state_q;
  logic [3:0]       stack_q [MAX_DIGITS];
  logic [WIDTH-2:0] acc_q;
  logic [3:0]       idx_q;
  logic [WIDTH-1:0] value_q;
  logic [3:0]       length_q;
  logic             neg_q;
  logic             ovf_q;

  logic [WIDTH-2:0] digitAcc_d;
  logic [WIDTH-2:0] rebuildAcc_d;
  logic [3:0]       rebuildDigit;

  // acc*10 + digit, formed from two shifts so no multiplier is inferred.
  // The MAX_DIGITS guard keeps the result inside WIDTH-1 bits.
  function automatic logic [WIDTH-2:0] mulTenAdd(input logic [WIDTH-2:0] acc,
                                                 input logic [3:0]       digit);
    logic [WIDTH-1:0] wide;
    wide = ({1'b0, acc} << 3) + ({1'b0, acc} << 1) + WIDTH'(digit);
    return wide[WIDTH-2:0];
  endfunction

  // Zero-extend the magnitude and negate it when the sign flag is set.
  // A zero magnitude stays zero, so there is never a -0.
  function automatic logic [WIDTH-1:0] applySign(input logic             neg,
                                                 input logic [WIDTH-2:0] mag);
    logic [WIDTH-1:0] ext;
    ext = {1'b0, mag};
    return neg ? (~ext + WIDTH'(1)) : ext;
  endfunction

  // Select d[idx-1] with an explicit compare so idx=0 never indexes out of range.
  always_comb begin
    rebuildDigit = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (idx_q == 4'(i + 1)) rebuildDigit = stack_q[i];
    end
  end

  assign digitAcc_d   = mulTenAdd(acc_q, key_code);
  assign rebuildAcc_d = mulTenAdd(acc_q, rebuildDigit);

  // Main FSM. In IDLE every key completes in one edge. A backspace drops the
  // low digit from the stack and then replays the remaining digits MSB-first
  // during REBUILD. value/length keep their old values until the final
  // publish edge. On that edge length is simply the old length minus one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      for (int i = 0; i < MAX_DIGITS; i++) stack_q[i] <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      value_q  <= '0;
      length_q <= '0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ovf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            case (key_code)
              4'd10: begin
                neg_q   <= ~neg_q;
                value_q <= applySign(~neg_q, acc_q);
              end
              4'd11: begin
                if (length_q != 4'd0) begin
                  for (int i = 0; i < MAX_DIGITS - 1; i++) stack_q[i] <= stack_q[i+1];
                  stack_q[MAX_DIGITS-1] <= '0;
                  acc_q   <= '0;
                  idx_q   <= length_q - 4'd1;
                  state_q <= REBUILD;
                end
              end
              4'd12: begin
                for (int i = 0; i < MAX_DIGITS; i++) stack_q[i] <= '0;
                acc_q    <= '0;
                length_q <= '0;
                neg_q    <= 1'b0;
                value_q  <= '0;
              end
              default: begin
                if (key_code <= 4'd9) begin
                  if (length_q == 4'(MAX_DIGITS)) begin
                    ovf_q <= 1'b1;
                  end else if (!(key_code == 4'd0 && length_q == 4'd0)) begin
                    // A leading zero leaves the entry empty.
                    for (int i = MAX_DIGITS - 1; i > 0; i--) stack_q[i] <= stack_q[i-1];
                    stack_q[0] <= key_code;
                    acc_q      <= digitAcc_d;
                    length_q   <= length_q + 4'd1;
                    value_q    <= applySign(neg_q, digitAcc_d);
                  end
                end
              end
            endcase
          end
        end
        REBUILD: begin
          if (idx_q != 4'd0) begin
            acc_q <= rebuildAcc_d;
            idx_q <= idx_q - 4'd1;
          end else begin
            value_q  <= applySign(neg_q, acc_q);
            length_q <= length_q - 4'd1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_ready    = (state_q == IDLE);
  assign busy         = (state_q == REBUILD);
  assign value        = value_q;
  assign length       = length_q;
  assign negative     = neg_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_digit_entry.sv
// tb_digit_entry
// Self-checking bench for digit_entry. A reference model holds the entry as
// a plain list of decimal digits plus a sign. It computes the operand by
// ordinary integer arithmetic and counts down backspace busy time from the
// number of digits that remain. Directed sequences come first, then
// randomized key traffic.
module tb_digit_entry;

  logic        clk;
  logic        reset;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready;
  logic [20:0] value;
  logic [3:0]  length;
  logic        negative;
  logic        busy;
  logic        overflow_err;

  int vectors;
  int miscompares;

  // Reference model state
  int digits[$];      // most significant digit first
  bit mNeg;
  int mValue;
  int mLen;
  int busyLeft;
  bit mOvf;

  digit_entry #(.WIDTH(21), .MAX_DIGITS(6)) dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_ready(key_ready),
    .value(value),
    .length(length),
    .negative(negative),
    .busy(busy),
    .overflow_err(overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int magnitude();
    int m = 0;
    foreach (digits[i]) m = m * 10 + digits[i];
    return m;
  endfunction

  function automatic void publish();
    mValue = mNeg ? -magnitude() : magnitude();
    mLen   = digits.size();
  endfunction

  // Advance the model by one rising edge with the given inputs.
  function automatic void modelEdge(input bit rst, input bit v, input int code);
    if (rst) begin
      digits.delete();
      mNeg = 0; mValue = 0; mLen = 0; busyLeft = 0; mOvf = 0;
      return;
    end
    mOvf = 0;
    if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) publish();
    end else if (v) begin
      if (code <= 9) begin
        if (digits.size() == 6) mOvf = 1;
        else if (!(code == 0 && digits.size() == 0)) begin
          digits.push_back(code);
          publish();
        end
      end else if (code == 10) begin
        mNeg = !mNeg;
        publish();
      end else if (code == 11) begin
        if (digits.size() > 0) begin
          void'(digits.pop_back());
          busyLeft = digits.size() + 1;
        end
      end else if (code == 12) begin
        digits.delete();
        mNeg = 0;
        publish();
      end
    end
  endfunction

  task automatic compareAll();
    logic [20:0] ev;
    ev = mValue[20:0];
    checkOutput("value", 32'(value), 32'(ev));
    checkOutput("length", 32'(length), 32'(mLen));
    checkOutput("negative", 32'(negative), 32'(mNeg));
    checkOutput("busy", 32'(busy), 32'(busyLeft > 0));
    checkOutput("key_ready", 32'(key_ready), 32'(busyLeft == 0));
    checkOutput("overflow_err", 32'(overflow_err), 32'(mOvf));
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model, check.
  task automatic applyStimulus(input bit rst, input bit v, input int code);
    reset     = rst;
    key_valid = v;
    key_code  = 4'(code);
    @(posedge clk);
    modelEdge(rst, v, code);
    #1;
    compareAll();
  endtask

  task automatic pressKey(input int code);
    applyStimulus(1'b0, 1'b1, code);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 0);
  endtask

  initial begin
    int r;
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1; key_valid = 1'b0; key_code = 4'd0;
    digits.delete();
    mNeg = 0; mValue = 0; mLen = 0; busyLeft = 0; mOvf = 0;

    applyStimulus(1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 5);   // reset wins over a key in the same cycle
    checkOutput("reset_value", 32'(value), 32'd0);

    // 1,2,3 then negate twice
    pressKey(1); pressKey(2); pressKey(3);
    checkOutput("val_123", 32'(value), 32'd123);
    pressKey(10);
    checkOutput("val_neg123", 32'(value), 32'h1FFF85);
    pressKey(10);
    checkOutput("val_pos123", 32'(value), 32'd123);

    // leading zeros
    pressKey(12);
    pressKey(0); pressKey(0); pressKey(5);
    checkOutput("lead_zero", 32'(value), 32'd5);

    // six nines then overflow
    pressKey(12);
    for (int i = 0; i < 6; i++) pressKey(9);
    pressKey(9);
    checkOutput("ovf_pulse", 32'(overflow_err), 32'd1);
    idleCycle();
    checkOutput("ovf_hold", 32'(value), 32'd999999);

    // -123 backspace with keys offered during busy, then empty it
    pressKey(12);
    pressKey(1); pressKey(2); pressKey(3); pressKey(10);
    pressKey(11);
    pressKey(7); pressKey(7); pressKey(7);
    checkOutput("bs_neg12", 32'(value), 32'h1FFFF4);
    pressKey(11); idleCycle(); idleCycle();
    pressKey(11); idleCycle();
    checkOutput("bs_empty_neg", 32'(negative), 32'd1);
    checkOutput("bs_empty_val", 32'(value), 32'd0);
    pressKey(10); pressKey(11); pressKey(4);

    // 4,5,6,7, backspace, reset on the second busy cycle
    pressKey(12);
    pressKey(4); pressKey(5); pressKey(6); pressKey(7);
    pressKey(11);
    idleCycle();
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("rst_rebuild_ready", 32'(key_ready), 32'd1);
    checkOutput("rst_rebuild_len", 32'(length), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyStimulus(1'b1, $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
      end else begin
        r = int'($urandom_range(0, 99));
        if (r < 55)      pressKey(int'($urandom_range(0, 9)));
        else if (r < 63) pressKey(10);
        else if (r < 75) pressKey(11);
        else if (r < 79) pressKey(12);
        else if (r < 84) pressKey(int'($urandom_range(13, 15)));
        else             idleCycle();
      end
    end

    key_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
